// File: rtl/nbit_muldiv_pkg.sv
// Shared definitions for the nbit_muldiv divider/multiplier pair.
// Holds the engine state encoding and the default operand width.
package nbit_muldiv_pkg;

    localparam int unsigned DefaultSize = 33;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/nbit_mult_engine.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, 2*SIZE-bit exact product.
// Signed mode subtracts the final partial product, which carries the multiplier sign weight.
module nbit_mult_engine
    import nbit_muldiv_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_signed_i,
    input  logic [SIZE-1:0]   multiplicand_i,
    input  logic [SIZE-1:0]   multiplier_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [2*SIZE-1:0] product_o
);

    localparam int unsigned CntW = $clog2(SIZE);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*SIZE-1:0] mcand_q, mcand_d;
    logic [2*SIZE-1:0] acc_q, acc_d;
    logic [SIZE-1:0]   mplier_q, mplier_d;
    logic              signed_q, signed_d;
    logic              last;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        signed_d = signed_q;
        last     = (cnt_q == CntW'(SIZE - 1));
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StBusy;
                    cnt_d    = '0;
                    acc_d    = '0;
                    signed_d = is_signed_i;
                    mplier_d = multiplier_i;
                    mcand_d  = is_signed_i ? {{SIZE{multiplicand_i[SIZE-1]}}, multiplicand_i}
                                           : {{SIZE{1'b0}}, multiplicand_i};
                end
            end
            StBusy: begin
                if (mplier_q[0]) begin
                    acc_d = (last && signed_q) ? acc_q - mcand_q : acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            signed_q <= signed_d;
        end
    end

    assign ready_o   = (state_q == StIdle);
    assign valid_o   = (state_q == StDone);
    assign product_o = acc_q;

endmodule

// File: rtl/nbit_muldiv.sv
// Independent restoring divider (inline) and optional shift-add multiplier.
// The multiplier is built only when NBIT_MULDIV_MULT_EN is defined; otherwise its outputs are 0.
module nbit_muldiv
    import nbit_muldiv_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_start,
    input  logic              div_is_signed,
    output logic              div_ready,
    output logic              div_valid,
    output logic              div_error,
    input  logic [SIZE-1:0]   div_dividend,
    input  logic [SIZE-1:0]   div_divisor,
    output logic [SIZE-1:0]   div_quotient,
    output logic [SIZE-1:0]   div_remainder,
    input  logic              mul_start,
    input  logic              mul_is_signed,
    output logic              mul_ready,
    output logic              mul_valid,
    input  logic [SIZE-1:0]   mul_multiplicand,
    input  logic [SIZE-1:0]   mul_multiplier,
    output logic [2*SIZE-1:0] mul_product
);

    localparam int unsigned CntW = $clog2(SIZE + 1);

    state_e          div_state_q, div_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic [SIZE-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;
    logic [SIZE-1:0] dvd_abs, dvs_abs;
    logic [SIZE:0]   rem_shift, diff;

    // quo_q doubles as the dividend shift register while busy.
    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_d      = zero_q;
        err_d       = err_q;
        dvd_abs     = (div_is_signed && div_dividend[SIZE-1]) ? -div_dividend : div_dividend;
        dvs_abs     = (div_is_signed && div_divisor[SIZE-1]) ? -div_divisor : div_divisor;
        rem_shift   = {rem_q, quo_q[SIZE-1]};
        diff        = rem_shift - {1'b0, dvs_q};
        unique case (div_state_q)
            StIdle: begin
                if (div_start) begin
                    div_state_d = StBusy;
                    cnt_d       = '0;
                    quo_d       = dvd_abs;
                    rem_d       = '0;
                    dvs_d       = dvs_abs;
                    neg_quo_d   = div_is_signed & (div_dividend[SIZE-1] ^ div_divisor[SIZE-1]);
                    neg_rem_d   = div_is_signed & div_dividend[SIZE-1];
                    zero_d      = (div_divisor == '0);
                end
            end
            StBusy: begin
                if (cnt_q != CntW'(SIZE)) begin
                    quo_d = {quo_q[SIZE-2:0], ~diff[SIZE]};
                    rem_d = diff[SIZE] ? rem_shift[SIZE-1:0] : diff[SIZE-1:0];
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    // Sign fix-up; a zero divisor already left |dividend| in the remainder.
                    quo_d       = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
                    rem_d       = neg_rem_q ? -rem_q : rem_q;
                    err_d       = zero_q;
                    div_state_d = StDone;
                end
            end
            StDone:  div_state_d = StIdle;
            default: div_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign div_ready     = (div_state_q == StIdle);
    assign div_valid     = (div_state_q == StDone);
    assign div_error     = err_q;
    assign div_quotient  = quo_q;
    assign div_remainder = rem_q;

`ifdef NBIT_MULDIV_MULT_EN
    nbit_mult_engine #(
        .SIZE(SIZE)
    ) u_mult (
        .clk            (clk),
        .rst            (rst),
        .start_i        (mul_start),
        .is_signed_i    (mul_is_signed),
        .multiplicand_i (mul_multiplicand),
        .multiplier_i   (mul_multiplier),
        .ready_o        (mul_ready),
        .valid_o        (mul_valid),
        .product_o      (mul_product)
    );
`else
    logic unused_mul;
    assign unused_mul  = ^{mul_start, mul_is_signed, mul_multiplicand, mul_multiplier};
    assign mul_ready   = 1'b0;
    assign mul_valid   = 1'b0;
    assign mul_product = '0;
`endif

endmodule

// File: tb/tb_nbit_muldiv.sv
// Scoreboard bench for nbit_muldiv: stimulus pushes expected results, a monitor pops on valid.
module tb_nbit_muldiv;

    localparam int unsigned SZ = 33;

    typedef logic [SZ-1:0]   w_t;
    typedef logic [2*SZ-1:0] p_t;
    typedef struct {w_t q; w_t r; logic err; int cyc;} div_exp_t;
    typedef struct {p_t p; int cyc;} mul_exp_t;

    logic clk, rst;
    logic div_start, div_is_signed, div_ready, div_valid, div_error;
    w_t   div_dividend, div_divisor, div_quotient, div_remainder;
    logic mul_start, mul_is_signed, mul_ready, mul_valid;
    w_t   mul_multiplicand, mul_multiplier;
    p_t   mul_product;

    nbit_muldiv #(
        .SIZE(SZ)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .div_start        (div_start),
        .div_is_signed    (div_is_signed),
        .div_ready        (div_ready),
        .div_valid        (div_valid),
        .div_error        (div_error),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder),
        .mul_start        (mul_start),
        .mul_is_signed    (mul_is_signed),
        .mul_ready        (mul_ready),
        .mul_valid        (mul_valid),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    div_exp_t div_sb[$];
    mul_exp_t mul_sb[$];

    task automatic check(input string name, input p_t act, input p_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every valid pulse against the head of the matching queue.
    initial begin : monitor
        div_exp_t de;
        mul_exp_t me;
        forever begin
            @(negedge clk);
            if (div_valid) begin
                if (div_sb.size() == 0) begin
                    check("div_valid_unexpected", p_t'(div_valid), p_t'(0));
                end else begin
                    de = div_sb.pop_front();
                    check("div_quotient", p_t'(div_quotient), p_t'(de.q));
                    check("div_remainder", p_t'(div_remainder), p_t'(de.r));
                    check("div_error", p_t'(div_error), p_t'(de.err));
                    check("div_latency", p_t'(cyc), p_t'(de.cyc));
                end
            end
            if (mul_valid) begin
                if (mul_sb.size() == 0) begin
                    check("mul_valid_unexpected", p_t'(mul_valid), p_t'(0));
                end else begin
                    me = mul_sb.pop_front();
                    check("mul_product", mul_product, me.p);
                    check("mul_latency", p_t'(cyc), p_t'(me.cyc));
                end
            end
        end
    end

    // Advance one cycle, drop starts and scramble operands to prove they were captured.
    task automatic step();
        @(posedge clk);
        #1;
        div_start        = 1'b0;
        mul_start        = 1'b0;
        div_dividend     = ~div_dividend;
        div_divisor      = ~div_divisor;
        div_is_signed    = ~div_is_signed;
        mul_multiplicand = ~mul_multiplicand;
        mul_multiplier   = ~mul_multiplier;
        mul_is_signed    = ~mul_is_signed;
    endtask

    task automatic wait_div_ready();
        int t = 0;
        while (!div_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("div_ready_wait", p_t'(div_ready), p_t'(1));
    endtask

    task automatic drain();
        int t = 0;
        while ((div_sb.size() + mul_sb.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", p_t'(div_sb.size() + mul_sb.size()), p_t'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic div_set(input w_t dvd, input w_t dvs, input logic sgn,
                           input w_t eq, input w_t er, input logic ee);
        div_exp_t e;
        div_dividend  = dvd;
        div_divisor   = dvs;
        div_is_signed = sgn;
        div_start     = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.err = ee;
        e.cyc = cyc + 1 + SZ + 1;
        div_sb.push_back(e);
    endtask

    task automatic div_op(input w_t dvd, input w_t dvs, input logic sgn,
                          input w_t eq, input w_t er, input logic ee);
        wait_div_ready();
        div_set(dvd, dvs, sgn, eq, er, ee);
        step();
        drain();
    endtask

`ifdef NBIT_MULDIV_MULT_EN
    task automatic mul_set(input w_t a, input w_t b, input logic sgn, input p_t ep);
        mul_exp_t e;
        check("mul_ready_before_start", p_t'(mul_ready), p_t'(1));
        mul_multiplicand = a;
        mul_multiplier   = b;
        mul_is_signed    = sgn;
        mul_start        = 1'b1;
        e.p   = ep;
        e.cyc = cyc + 1 + SZ;
        mul_sb.push_back(e);
    endtask
`endif

    initial begin : stim
        w_t most_neg;
        most_neg         = {1'b1, {(SZ-1){1'b0}}};
        rst              = 1'b1;
        div_start        = 1'b0;
        div_is_signed    = 1'b0;
        div_dividend     = '0;
        div_divisor      = '0;
        mul_start        = 1'b0;
        mul_is_signed    = 1'b0;
        mul_multiplicand = '0;
        mul_multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_div_ready", p_t'(div_ready), p_t'(1));
        check("rst_div_valid", p_t'(div_valid), p_t'(0));
        check("rst_div_error", p_t'(div_error), p_t'(0));
        check("rst_div_quotient", p_t'(div_quotient), p_t'(0));
        check("rst_div_remainder", p_t'(div_remainder), p_t'(0));
        check("rst_mul_product", mul_product, p_t'(0));
        check("rst_mul_valid", p_t'(mul_valid), p_t'(0));
`ifdef NBIT_MULDIV_MULT_EN
        check("rst_mul_ready", p_t'(mul_ready), p_t'(1));
`else
        check("rst_mul_ready", p_t'(mul_ready), p_t'(0));
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        div_op(w_t'(100), w_t'(7), 1'b0, w_t'(14), w_t'(2), 1'b0);
        div_op(w_t'(-7), w_t'(2), 1'b1, w_t'(-3), w_t'(-1), 1'b0);
        div_op(w_t'(7), w_t'(-2), 1'b1, w_t'(-3), w_t'(1), 1'b0);
        div_op(most_neg, w_t'(-1), 1'b1, most_neg, w_t'(0), 1'b0);
        div_op(w_t'(-1), w_t'(2), 1'b0, w_t'(33'h0_FFFF_FFFF), w_t'(1), 1'b0);
        div_op(w_t'(5), w_t'(0), 1'b1, w_t'(-1), w_t'(5), 1'b1);

        // A second start while busy must be ignored.
        wait_div_ready();
        div_set(w_t'(100), w_t'(7), 1'b0, w_t'(14), w_t'(2), 1'b0);
        step();
        repeat (4) step();
        check("div_ready_busy", p_t'(div_ready), p_t'(0));
        div_dividend = w_t'(50);
        div_divisor  = w_t'(5);
        div_start    = 1'b1;
        step();
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("hold_quotient", p_t'(div_quotient), p_t'(14));
        check("hold_remainder", p_t'(div_remainder), p_t'(2));

`ifdef NBIT_MULDIV_MULT_EN
        wait_div_ready();
        mul_set(w_t'(32'hFFFF_FFFF), w_t'(32'hFFFF_FFFF), 1'b0, p_t'(64'hFFFF_FFFE_0000_0001));
        step();
        drain();
        mul_set(w_t'(-3), w_t'(5), 1'b1, p_t'(-15));
        step();
        drain();
        mul_set(most_neg, most_neg, 1'b1, p_t'(1) << (2 * SZ - 2));
        step();
        drain();
        // Both engines started in the same cycle.
        div_set(w_t'(-100), w_t'(7), 1'b1, w_t'(-14), w_t'(-2), 1'b0);
        mul_set(w_t'(-3), w_t'(-5), 1'b1, p_t'(15));
        step();
        drain();
`else
        mul_multiplicand = w_t'(3);
        mul_multiplier   = w_t'(5);
        mul_start        = 1'b1;
        step();
        repeat (SZ + 2) @(posedge clk);
        #1;
        check("nomul_ready", p_t'(mul_ready), p_t'(0));
        check("nomul_valid", p_t'(mul_valid), p_t'(0));
        check("nomul_product", mul_product, p_t'(0));
`endif

        // Reset mid-division: aborted, no valid pulse, results cleared.
        div_op(w_t'(5), w_t'(0), 1'b0, w_t'(-1), w_t'(5), 1'b1);
        div_dividend = w_t'(100);
        div_divisor  = w_t'(7);
        div_start    = 1'b1;
        step();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_div_ready", p_t'(div_ready), p_t'(1));
        check("abort_div_error", p_t'(div_error), p_t'(0));
        check("abort_div_quotient", p_t'(div_quotient), p_t'(0));
        check("abort_div_remainder", p_t'(div_remainder), p_t'(0));
        repeat (SZ + 5) @(posedge clk);
        #1;

        // Reset wins over a simultaneous start.
        rst          = 1'b1;
        div_start    = 1'b1;
        div_dividend = w_t'(9);
        div_divisor  = w_t'(3);
        mul_start    = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        div_start = 1'b0;
        mul_start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_div_ready", p_t'(div_ready), p_t'(1));
        repeat (SZ + 5) @(posedge clk);
        #1;
        check("rst_start_div_quotient", p_t'(div_quotient), p_t'(0));

        div_op(w_t'(9), w_t'(3), 1'b0, w_t'(3), w_t'(0), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nbit_muldiv.md
NBIT_MULDIV -- requirements
Module: nbit_muldiv

Interface
REQ-001 SHALL have parameter SIZE, default 33, operand width in bits; SIZE >= 2.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port div_start, input, 1, request a division.
REQ-005 SHALL have port div_is_signed, input, 1, treat div operands as two's complement.
REQ-006 SHALL have port div_ready, output, 1, divider idle and able to accept div_start.
REQ-007 SHALL have port div_valid, output, 1, one-cycle pulse when the division result is available.
REQ-008 SHALL have port div_error, output, 1, last division had divisor zero.
REQ-009 SHALL have ports div_dividend and div_divisor, input, SIZE, division operands.
REQ-010 SHALL have ports div_quotient and div_remainder, output, SIZE, division results.
REQ-011 SHALL have ports mul_start, mul_is_signed, input, 1, multiply request and signedness.
REQ-012 SHALL have ports mul_ready and mul_valid, output, 1, same meaning as the divider pair.
REQ-013 SHALL have ports mul_multiplicand and mul_multiplier, input, SIZE, multiply operands.
REQ-014 SHALL have port mul_product, output, 2*SIZE, full-width product.

Function
REQ-015 Each engine SHALL run a three-state FSM: IDLE -> BUSY on start&&ready; BUSY -> DONE at last iteration; DONE -> IDLE after one cycle.
REQ-016 ready SHALL be 1 only in IDLE; start while not IDLE SHALL be ignored.
REQ-017 Operands and is_signed SHALL be captured on the edge that accepts start; later input changes SHALL have no effect.
REQ-018 Divider: restoring, one quotient bit per cycle; div_valid SHALL be high exactly in the cycle SIZE+1 cycles after the accepting edge.
REQ-019 Multiplier: shift-add, one multiplier bit per cycle; mul_valid SHALL be high exactly in the cycle SIZE cycles after the accepting edge.
REQ-020 Results SHALL be valid combinationally in the valid cycle and held unchanged until the next accepted start.
REQ-021 Signed division SHALL truncate toward zero; remainder SHALL take the sign of the dividend; dividend = q*divisor + r.
REQ-022 Divisor zero SHALL give div_error=1, quotient all ones, and remainder = dividend, with normal latency; otherwise div_error=0.
REQ-023 Signed most-negative / -1 SHALL give quotient = dividend and remainder 0, with no error.
REQ-024 Signed multiply SHALL treat both operands as two's complement; unsigned SHALL treat both as unsigned; the product SHALL be exact in 2*SIZE bits.
REQ-025 Engines SHALL be independent and SHALL be able to run concurrently.
REQ-026 Simultaneous start and valid-cycle SHALL NOT overlap; start is accepted only in IDLE.

Reset
REQ-027 On rst=1: both FSMs SHALL go to IDLE, with ready=1, valid=0, and div_error=0.
REQ-028 On rst=1: quotient, remainder, and product SHALL be cleared to 0.
REQ-029 rst SHALL abort an in-flight operation, with no valid pulse.
REQ-030 rst SHALL take priority over a simultaneous start.

Configuration
REQ-031 Macro NBIT_MULDIV_MULT_EN defined: the multiplier engine SHALL be present.
REQ-032 Macro NBIT_MULDIV_MULT_EN undefined: mul_ready=0, mul_valid=0, and mul_product=0 constant, with mul_start ignored; the divider SHALL be unaffected.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, BUSY, DONE) and default SIZE constant.
REQ-034 The multiplier SHALL be a sub-module nbit_mult_engine instantiated under the macro; the divider SHALL be inline.

Verification
REQ-035 Unsigned 100/7 -> quotient 14, remainder 2, div_error 0, valid at accept+SIZE+1.
REQ-036 Signed -7/2 -> quotient -3, remainder -1.
REQ-037 Signed 5/0 -> div_error 1, quotient all ones, remainder 5.
REQ-038 Multiply, SIZE=33: unsigned 0xFFFFFFFF*0xFFFFFFFF -> product 0xFFFFFFFE00000001; signed -3*5 -> -15 sign-extended to 66 bits.
REQ-039 rst asserted mid-division -> no div_valid pulse; div_ready=1 in the cycle after rst.
REQ-040 div_start pulsed while BUSY -> ignored; the original result is unchanged.
